auv_csr_ctrl: RTL and testbench
===============================

AUV_CSR_CTRL -- requirements
Module: auv_csr_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8, cycles without slave ack before abort (range 2..255).
REQ-002 SHALL have port clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports csr_req in 1 (EX-stage CSR request); csr_op in 2 (1=RW, 2=RS, 3=RC, 0=reserved); csr_addr in 12; csr_wdata in 32.
REQ-004 SHALL have ports rd_x0 in 1 (destination is x0) and rs1_x0 in 1 (source is x0 or zero immediate).
REQ-005 SHALL have port flush in 1, which aborts the pipeline.
REQ-006 SHALL have ports csr_stall out 1, csr_done out 1 (pulse), csr_rdata out 32 (old CSR value), exc_illegal_inst_csr out 1 (pulse).
REQ-007 SHALL have bus ports cbus_sel out 2 (one-hot slave select), cbus_adr out 7, cbus_dat_wr out 32, cbus_rd out 1, cbus_wr out 1, cbus_dat_rd0/cbus_dat_rd1 in 32, cbus_ack in 2.

Function
REQ-010 SHALL decode slave 0 (trap controller) for csr_addr 0x300-0x37F.
REQ-011 SHALL decode slave 1 (counters) for csr_addr 0xB00-0xB7F and 0xC00-0xC7F.
REQ-012 SHALL drive cbus_adr = csr_addr[6:0].
REQ-013 SHALL treat csr_addr[11:10]==2'b11 as read-only.
REQ-014 SHALL implement the states IDLE, RD, WR, DONE and ILL.
REQ-015 In IDLE with csr_req, the block SHALL go to ILL if: no slave decodes, csr_op==0, or a write is required to a read-only address.
REQ-016 In IDLE with csr_req and no illegal condition, the block SHALL go to WR if op==RW and rd_x0; otherwise it SHALL go to RD.
REQ-017 A write SHALL be required for RW always, and for RS/RC only when rs1_x0 is 0.
REQ-018 In RD, the block SHALL assert cbus_sel[s] and cbus_rd, and hold them until cbus_ack[s].
REQ-019 On cbus_ack[s] in RD, the block SHALL latch the selected cbus_dat_rd into csr_rdata, then go to WR if a write is required, else to DONE.
REQ-020 WR SHALL compute new = RW: csr_wdata; RS: old|csr_wdata; RC: old&~csr_wdata.
REQ-021 WR SHALL assert cbus_sel[s], cbus_wr and cbus_dat_wr=new until cbus_ack[s], then go to DONE.
REQ-022 DONE SHALL pulse csr_done for 1 cycle, then go to IDLE; csr_rdata SHALL hold until the next RD capture.
REQ-023 ILL SHALL pulse exc_illegal_inst_csr for 1 cycle, assert no bus strobes, then go to IDLE.
REQ-024 csr_stall SHALL be combinational: (IDLE & csr_req) | RD | WR.
REQ-025 csr_stall SHALL be low in DONE and ILL.
REQ-026 The block SHALL ignore cbus_ack bits for the unselected slave.
REQ-027 Latency with a 1-cycle-ack slave SHALL be as follows, for req sampled at cycle 0: read-only gives done at cycle 3; read+write gives done at cycle 5; write-only (RW, rd_x0) gives done at cycle 3.
REQ-028 flush in IDLE or RD SHALL return the block to IDLE next cycle, with no done, no exc and no write.
REQ-029 flush in WR SHALL be ignored until ack; the write completes and csr_done is suppressed.
REQ-030 csr_req SHALL be ignored in all states except IDLE.

Reset
REQ-040 rst_n low SHALL force: state=IDLE, cbus_sel=0, cbus_rd=0, cbus_wr=0, cbus_adr=0, cbus_dat_wr=0, csr_rdata=0, csr_done=0, exc_illegal_inst_csr=0, and timeout counter=0.
REQ-041 Reset asserted mid-transfer SHALL drop strobes immediately (asynchronously) and issue no done or exc after release.

Configuration
REQ-050 With macro AUV_CSR_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to RD/WR and increment each RD/WR cycle without ack.
REQ-051 With AUV_CSR_TIMEOUT_EN defined, reaching TIMEOUT SHALL move the block to ILL, and strobes SHALL drop.
REQ-052 Without AUV_CSR_TIMEOUT_EN, no counter SHALL exist, and RD/WR SHALL wait indefinitely for ack.

Verification
REQ-060 csrrs 0x300, rs1_x0=1, slave0 acks at +1 with 0x88 -> no cbus_wr, csr_rdata=0x00000088, csr_done at cycle 3.
REQ-061 csrrc 0x304, csr_wdata=0x80, old=0x880 -> cbus_dat_wr=0x00000800 on slave0, csr_done at cycle 5.
REQ-062 csrrw 0xC00 (read-only), rs1_x0=0 -> exc_illegal_inst_csr pulse at cycle 1, cbus_sel stays 0; csrrw 0x7C0 (no slave) -> same response.
REQ-063 csrrw 0xB02, rd_x0=1, wdata=0x5 -> no cbus_rd, cbus_sel=2'b10, cbus_wr with data 0x5, csr_done at cycle 3.
REQ-064 AUV_CSR_TIMEOUT_EN defined, TIMEOUT=8, slave never acks -> exc pulse 9 cycles after req, strobes low; flush during RD -> IDLE with neither done nor exc.

Source files
------------

// File: rtl/auv_csr_ctrl.sv
// CSR access controller: decodes an EX-stage CSR instruction into read/write cycles on the CSR bus.
// Optional abort-on-silence timeout is enabled by defining AUV_CSR_TIMEOUT_EN.
module auv_csr_ctrl #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_csr_req,
  input  logic [1:0]  i_csr_op,
  input  logic [11:0] i_csr_addr,
  input  logic [31:0] i_csr_wdata,
  input  logic        i_rd_x0,
  input  logic        i_rs1_x0,
  input  logic        i_flush,
  output logic        o_csr_stall,
  output logic        o_csr_done,
  output logic [31:0] o_csr_rdata,
  output logic        o_exc_illegal_inst_csr,
  output logic [1:0]  o_cbus_sel,
  output logic [6:0]  o_cbus_adr,
  output logic [31:0] o_cbus_dat_wr,
  output logic        o_cbus_rd,
  output logic        o_cbus_wr,
  input  logic [31:0] i_cbus_dat_rd0,
  input  logic [31:0] i_cbus_dat_rd1,
  input  logic [1:0]  i_cbus_ack
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("auv_csr_ctrl: TIMEOUT must be in 2..255");
  end

  typedef enum logic [2:0] {StIdle, StRd, StWr, StDone, StIll} state_e;

  localparam logic [1:0] OpRw = 2'd1;
  localparam logic [1:0] OpRs = 2'd2;
  localparam logic [1:0] OpRc = 2'd3;

  state_e      r_state;
  logic [1:0]  r_sel;
  logic        r_rd;
  logic        r_wr;
  logic [6:0]  r_adr;
  logic [31:0] r_dat_wr;
  logic [31:0] r_rdata;
  logic        r_done;
  logic        r_exc;
  logic [1:0]  r_op;
  logic [31:0] r_wdata;
  logic        r_wr_req;
  logic        r_flushed;

  logic        w_hit0;
  logic        w_hit1;
  logic        w_ro;
  logic        w_wr_req;
  logic        w_illegal;
  logic        w_ack;
  logic        w_timeout;
  logic [31:0] w_dat_rd;
  logic [31:0] w_new;

  assign w_hit0    = (i_csr_addr[11:7] == 5'b00110);
  assign w_hit1    = (i_csr_addr[11:7] == 5'b10110) || (i_csr_addr[11:7] == 5'b11000);
  assign w_ro      = (i_csr_addr[11:10] == 2'b11);
  assign w_wr_req  = (i_csr_op == OpRw) || !i_rs1_x0;
  assign w_illegal = !(w_hit0 || w_hit1) || (i_csr_op == 2'd0) || (w_wr_req && w_ro);

  // Only the ack bit of the slave we are talking to counts.
  assign w_ack    = |(i_cbus_ack & r_sel);
  assign w_dat_rd = r_sel[1] ? i_cbus_dat_rd1 : i_cbus_dat_rd0;

  always_comb begin
    w_new = r_wdata;
    case (r_op)
      OpRs:    w_new = w_dat_rd | r_wdata;
      OpRc:    w_new = w_dat_rd & ~r_wdata;
      default: w_new = r_wdata;
    endcase
  end

`ifdef AUV_CSR_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       w_busy;

  assign w_busy    = (r_state == StRd) || (r_state == StWr);
  assign w_timeout = w_busy && !w_ack && (r_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_busy && !w_ack && !w_timeout) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_sel     <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_adr     <= '0;
      r_dat_wr  <= '0;
      r_rdata   <= '0;
      r_done    <= 1'b0;
      r_exc     <= 1'b0;
      r_op      <= '0;
      r_wdata   <= '0;
      r_wr_req  <= 1'b0;
      r_flushed <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_exc  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_csr_req && !i_flush) begin
            r_adr     <= i_csr_addr[6:0];
            r_op      <= i_csr_op;
            r_wdata   <= i_csr_wdata;
            r_wr_req  <= w_wr_req;
            r_flushed <= 1'b0;
            if (w_illegal) begin
              r_state <= StIll;
              r_exc   <= 1'b1;
            end else begin
              r_sel <= {w_hit1, w_hit0};
              if (i_csr_op == OpRw && i_rd_x0) begin
                r_state  <= StWr;
                r_wr     <= 1'b1;
                r_dat_wr <= i_csr_wdata;
              end else begin
                r_state <= StRd;
                r_rd    <= 1'b1;
              end
            end
          end
        end
        StRd: begin
          if (i_flush) begin
            r_state <= StIdle;
            r_sel   <= '0;
            r_rd    <= 1'b0;
          end else if (w_ack) begin
            r_rdata <= w_dat_rd;
            r_rd    <= 1'b0;
            if (r_wr_req) begin
              r_state  <= StWr;
              r_wr     <= 1'b1;
              r_dat_wr <= w_new;
            end else begin
              r_state <= StDone;
              r_sel   <= '0;
              r_done  <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state <= StIll;
            r_sel   <= '0;
            r_rd    <= 1'b0;
            r_exc   <= 1'b1;
          end
        end
        StWr: begin
          // A write already on the bus must complete; a flush only hides its done.
          if (w_ack) begin
            r_sel <= '0;
            r_wr  <= 1'b0;
            if (r_flushed || i_flush) begin
              r_state <= StIdle;
            end else begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state <= StIll;
            r_sel   <= '0;
            r_wr    <= 1'b0;
            r_exc   <= 1'b1;
          end else if (i_flush) begin
            r_flushed <= 1'b1;
          end
        end
        StDone:  r_state <= StIdle;
        StIll:   r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_csr_stall = ((r_state == StIdle) && i_csr_req) || (r_state == StRd) ||
                       (r_state == StWr);

  assign o_csr_done             = r_done;
  assign o_csr_rdata            = r_rdata;
  assign o_exc_illegal_inst_csr = r_exc;
  assign o_cbus_sel             = r_sel;
  assign o_cbus_adr             = r_adr;
  assign o_cbus_dat_wr          = r_dat_wr;
  assign o_cbus_rd              = r_rd;
  assign o_cbus_wr              = r_wr;

endmodule

// File: tb/tb_auv_csr_ctrl.sv
// Randomized bench for auv_csr_ctrl: behavioural CSR slaves plus a transaction-level model.
module tb_auv_csr_ctrl;

  logic        clk;
  logic        rst_n;
  logic        csr_req;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        rd_x0;
  logic        rs1_x0;
  logic        flush;
  logic        csr_stall;
  logic        csr_done;
  logic [31:0] csr_rdata;
  logic        exc;
  logic [1:0]  cbus_sel;
  logic [6:0]  cbus_adr;
  logic [31:0] cbus_dat_wr;
  logic        cbus_rd;
  logic        cbus_wr;
  logic [31:0] cbus_dat_rd0;
  logic [31:0] cbus_dat_rd1;
  logic [1:0]  cbus_ack;

  int n_checks = 0;
  int n_fail   = 0;

  auv_csr_ctrl #(.TIMEOUT(8)) u_dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .i_csr_req              (csr_req),
    .i_csr_op               (csr_op),
    .i_csr_addr             (csr_addr),
    .i_csr_wdata            (csr_wdata),
    .i_rd_x0                (rd_x0),
    .i_rs1_x0               (rs1_x0),
    .i_flush                (flush),
    .o_csr_stall            (csr_stall),
    .o_csr_done             (csr_done),
    .o_csr_rdata            (csr_rdata),
    .o_exc_illegal_inst_csr (exc),
    .o_cbus_sel             (cbus_sel),
    .o_cbus_adr             (cbus_adr),
    .o_cbus_dat_wr          (cbus_dat_wr),
    .o_cbus_rd              (cbus_rd),
    .o_cbus_wr              (cbus_wr),
    .i_cbus_dat_rd0         (cbus_dat_rd0),
    .i_cbus_dat_rd1         (cbus_dat_rd1),
    .i_cbus_ack             (cbus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int s, input int i);
    if (s == 0 && i == 0) return 32'h0000_0088;
    if (s == 0 && i == 4) return 32'h0000_0880;
    return (32'(i) * 32'h9E37_79B1) ^ (32'(s + 1) * 32'h5A5A_1234);
  endfunction

  // Slaves: registered ack after ack_dly extra cycles, writes commit on ack.
  logic [31:0] smem [2][128];
  logic [1:0]  s_ack;
  logic [1:0]  noise;
  int          s_wcnt;
  int          ack_dly  = 0;
  logic        ack_hold = 1'b0;

  always @(posedge clk) begin
    noise <= 2'($urandom);
    if (!rst_n) begin
      for (int s = 0; s < 2; s++)
        for (int i = 0; i < 128; i++) smem[s][i] <= init_val(s, i);
      s_ack  <= '0;
      s_wcnt <= 0;
    end else begin
      s_ack <= '0;
      if ((cbus_rd || cbus_wr) && s_ack == 2'b00 && !ack_hold) begin
        if (s_wcnt >= ack_dly) begin
          s_ack  <= cbus_sel;
          s_wcnt <= 0;
          if (cbus_wr) smem[cbus_sel[1] ? 1 : 0][cbus_adr] <= cbus_dat_wr;
        end else begin
          s_wcnt <= s_wcnt + 1;
        end
      end else if (!(cbus_rd || cbus_wr)) begin
        s_wcnt <= 0;
      end
    end
  end

  // Random chatter on the unselected ack line must be ignored.
  assign cbus_ack     = s_ack | (noise & ~cbus_sel);
  assign cbus_dat_rd0 = smem[0][cbus_adr];
  assign cbus_dat_rd1 = smem[1][cbus_adr];

  logic [31:0] mmem [2][128];
  logic [31:0] last_rdata;

  task automatic init_model();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 128; i++) mmem[s][i] = init_val(s, i);
    last_rdata = '0;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] wdata,
                       input logic rdx0, input logic rs1x0);
    @(posedge clk); #1;
    csr_req = 1'b1; csr_addr = addr; csr_op = op; csr_wdata = wdata;
    rd_x0 = rdx0; rs1_x0 = rs1x0;
    @(negedge clk);
    check_eq("stall_on_req", 32'(csr_stall), 32'd1);
    @(posedge clk); #1;
    csr_req = 1'b0;
  endtask

  // Watches ncyc cycles; cycle k is the k-th sample after the edge that took the request.
  task automatic observe(input int ncyc, input logic [1:0] esel, input logic [6:0] eadr,
                         output int dc, output int ec, output int nd, output int ne,
                         output int nr, output int nw, output logic [31:0] wd,
                         output int sb, output int sd);
    dc = 0; ec = 0; nd = 0; ne = 0; nr = 0; nw = 0; wd = '0; sb = 0; sd = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (csr_done) begin nd++; if (dc == 0) dc = k; if (csr_stall) sd++; end
      if (exc)      begin ne++; if (ec == 0) ec = k; if (csr_stall) sd++; end
      if (cbus_rd) nr++;
      if (cbus_wr) begin nw++; wd = cbus_dat_wr; end
      if (cbus_rd || cbus_wr) begin
        if (cbus_sel != esel || cbus_adr != eadr || (cbus_rd && cbus_wr)) sb++;
      end else if (cbus_sel != 2'b00) begin
        sb++;
      end
    end
  endtask

  task automatic run_txn(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] wdata,
                         input logic rdx0, input logic rs1x0, input int dly,
                         output logic [31:0] wd);
    int s, nph, dc, ec, nd, ne, nr, nw, sb, sd;
    logic ro, wreq, ill, rdn;
    logic [31:0] oldv, newv;
    logic [1:0]  esel;
    if (addr >= 12'h300 && addr <= 12'h37F) s = 0;
    else if ((addr >= 12'hB00 && addr <= 12'hB7F) || (addr >= 12'hC00 && addr <= 12'hC7F)) s = 1;
    else s = -1;
    ro   = (addr >= 12'hC00);
    wreq = (op == 2'd1) || !rs1x0;
    ill  = (s < 0) || (op == 2'd0) || (wreq && ro);
    rdn  = !(op == 2'd1 && rdx0);
    esel = (s == 0) ? 2'b01 : (s == 1) ? 2'b10 : 2'b00;
    oldv = '0;
    if (s >= 0) oldv = mmem[s][addr[6:0]];
    case (op)
      2'd2:    newv = oldv | wdata;
      2'd3:    newv = oldv & ~wdata;
      default: newv = wdata;
    endcase
    ack_dly = dly;
    issue(addr, op, wdata, rdx0, rs1x0);
    observe(16, esel, addr[6:0], dc, ec, nd, ne, nr, nw, wd, sb, sd);
    check_eq("bus_sel_adr", 32'(sb), 32'd0);
    check_eq("stall_in_done_ill", 32'(sd), 32'd0);
    if (ill) begin
      check_eq("ill_exc_cycle", 32'(ec), 32'd1);
      check_eq("ill_exc_pulses", 32'(ne), 32'd1);
      check_eq("ill_no_done", 32'(nd), 32'd0);
      check_eq("ill_no_strobe", 32'(nr + nw), 32'd0);
    end else begin
      nph = int'(rdn) + int'(wreq);
      check_eq("done_cycle", 32'(dc), 32'(1 + nph * (2 + dly)));
      check_eq("done_pulses", 32'(nd), 32'd1);
      check_eq("no_exc", 32'(ne), 32'd0);
      check_eq("rd_cycles", 32'(nr), rdn ? 32'(2 + dly) : 32'd0);
      check_eq("wr_cycles", 32'(nw), wreq ? 32'(2 + dly) : 32'd0);
      if (rdn) last_rdata = oldv;
      if (wreq) begin
        check_eq("wr_data", wd, newv);
        mmem[s][addr[6:0]] = newv;
      end
    end
    check_eq("rdata", csr_rdata, last_rdata);
    check_eq("idle_stall", 32'(csr_stall), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, ec, nd, ne, nr, nw, sb, sd;
    logic [31:0] wd, v;
    logic [11:0] a;
    rst_n = 1'b0; csr_req = 1'b0; csr_op = '0; csr_addr = '0; csr_wdata = '0;
    rd_x0 = 1'b0; rs1_x0 = 1'b0; flush = 1'b0;
    init_model();
    #12;
    check_eq("rst_sel", 32'(cbus_sel), 32'd0);
    check_eq("rst_strobes", 32'({cbus_rd, cbus_wr}), 32'd0);
    check_eq("rst_adr", 32'(cbus_adr), 32'd0);
    check_eq("rst_dat_wr", cbus_dat_wr, 32'd0);
    check_eq("rst_rdata", csr_rdata, 32'd0);
    check_eq("rst_pulses", 32'({csr_done, exc}), 32'd0);
    check_eq("rst_stall", 32'(csr_stall), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed cases from the block's reference scenarios.
    run_txn(12'h300, 2'd2, 32'h0, 1'b0, 1'b1, 0, wd);
    check_eq("csrrs_rdata", csr_rdata, 32'h0000_0088);
    run_txn(12'h304, 2'd3, 32'h80, 1'b0, 1'b0, 0, wd);
    check_eq("csrrc_wdata", wd, 32'h0000_0800);
    check_eq("csrrc_rdata", csr_rdata, 32'h0000_0880);
    run_txn(12'hC00, 2'd1, 32'h1234, 1'b0, 1'b0, 0, wd);
    run_txn(12'h7C0, 2'd1, 32'h1234, 1'b0, 1'b0, 0, wd);
    run_txn(12'hB02, 2'd1, 32'h5, 1'b1, 1'b0, 0, wd);
    check_eq("csrrw_wo_wdata", wd, 32'h5);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0:       a = 12'h300 + 12'($urandom_range(0, 127));
        1:       a = 12'hB00 + 12'($urandom_range(0, 127));
        2:       a = 12'hC00 + 12'($urandom_range(0, 127));
        default: a = 12'($urandom);
      endcase
      run_txn(a, 2'($urandom_range(0, 3)), $urandom, 1'($urandom), 1'($urandom),
              $urandom_range(0, 2), wd);
    end

    // Flush while reading: back to idle, nothing reported, nothing written.
    ack_hold = 1'b1;
    issue(12'h310, 2'd2, 32'h0, 1'b0, 1'b1);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    observe(6, 2'b01, 7'h10, dc, ec, nd, ne, nr, nw, wd, sb, sd);
    check_eq("flush_rd_quiet", 32'(nd + ne + nr + nw + sb), 32'd0);
    check_eq("flush_rd_stall", 32'(csr_stall), 32'd0);
    ack_hold = 1'b0;

    // Flush during a write: write lands, done is hidden.
    ack_dly = 2;
    v = $urandom;
    issue(12'hB05, 2'd1, v, 1'b1, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    observe(10, 2'b10, 7'h05, dc, ec, nd, ne, nr, nw, wd, sb, sd);
    check_eq("flush_wr_cycles", 32'(nw), 32'd3);
    check_eq("flush_wr_no_done", 32'(nd + ne), 32'd0);
    check_eq("flush_wr_data", wd, v);
    check_eq("flush_wr_landed", smem[1][5], v);
    mmem[1][5] = v;

    // Flush in idle alongside a request: request is dropped.
    @(posedge clk); #1;
    csr_req = 1'b1; flush = 1'b1; csr_addr = 12'h301; csr_op = 2'd1; rd_x0 = 1'b0;
    @(posedge clk); #1 csr_req = 1'b0; flush = 1'b0;
    observe(6, 2'b01, 7'h01, dc, ec, nd, ne, nr, nw, wd, sb, sd);
    check_eq("flush_idle_quiet", 32'(nd + ne + nr + nw + sb), 32'd0);

    // Silent slave.
    ack_hold = 1'b1;
    issue(12'h305, 2'd2, 32'h0, 1'b0, 1'b1);
`ifdef AUV_CSR_TIMEOUT_EN
    observe(12, 2'b01, 7'h05, dc, ec, nd, ne, nr, nw, wd, sb, sd);
    check_eq("timeout_exc_cycle", 32'(ec), 32'd9);
    check_eq("timeout_rd_cycles", 32'(nr), 32'd8);
    check_eq("timeout_no_done", 32'(nd), 32'd0);
    check_eq("timeout_strobes", 32'({cbus_rd, cbus_wr, cbus_sel}), 32'd0);
`else
    observe(20, 2'b01, 7'h05, dc, ec, nd, ne, nr, nw, wd, sb, sd);
    check_eq("wait_no_exc", 32'(ne + nd), 32'd0);
    check_eq("wait_rd_cycles", 32'(nr), 32'd20);
    check_eq("wait_stall", 32'(csr_stall), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check_eq("wait_flushed", 32'({cbus_rd, cbus_sel}), 32'd0);
`endif
    ack_hold = 1'b0;

    // Asynchronous reset mid-read.
    ack_hold = 1'b1;
    issue(12'h301, 2'd2, 32'h0, 1'b0, 1'b1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check_eq("arst_strobes", 32'({cbus_rd, cbus_wr, cbus_sel}), 32'd0);
    check_eq("arst_rdata", csr_rdata, 32'd0);
    @(posedge clk); #1 ack_hold = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    init_model();
    observe(6, 2'b01, 7'h01, dc, ec, nd, ne, nr, nw, wd, sb, sd);
    check_eq("arst_quiet", 32'(nd + ne + nr + nw), 32'd0);
    run_txn(12'hB10, 2'd3, $urandom, 1'b0, 1'b0, 1, wd);
    run_txn(12'hC20, 2'd2, $urandom, 1'b0, 1'b1, 0, wd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
